// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types and default geometry for the CNN pixel front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int c_GS_BITS = 8;
    localparam int c_D_WIDTH = 16;
    localparam int c_IMG_DIM = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        WAIT = 2'd2
    } ingress_state_t;

    // A 1x1 frame still needs a one-bit position field.
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_N_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_N_counter
//  Description : Enabled modulo-N up counter with a wrap strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_N_counter #(
    parameter int N = 30,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    localparam logic [W-1:0] c_MAX = W'(N - 1);

    logic [W-1:0] r_count;

    // Wrap is only meaningful on an enabled step, so it can chain counters.
    assign o_wrap  = i_en && (r_count == c_MAX);
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_MAX) ? '0 : r_count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_ingress
//  Description : Raster-position tracking, widening and FIFO write of incoming
//                grayscale pixels; holds off after each frame until classified.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_ingress
    import cnn_pkg::*;
#(
    parameter int GS_BITS   = c_GS_BITS,
    parameter int D_WIDTH   = c_D_WIDTH,
    parameter int IMG_DIM   = c_IMG_DIM,
    parameter int PIX_SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic [GS_BITS-1:0]            pixel_i,
    input  logic                          pixel_i_valid,
    input  logic                          result_valid_i,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [D_WIDTH-1:0]            fifo_din,
    output logic [pos_width(IMG_DIM)-1:0] row_o,
    output logic [pos_width(IMG_DIM)-1:0] col_o,
    output logic                          frame_start_o,
    output logic                          frame_done_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic                          drop_o
);

    localparam int c_POS_W = pos_width(IMG_DIM);

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_RECV = RECV;
    localparam logic [1:0] c_ST_WAIT = WAIT;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_first;
    logic               w_last;
    logic [c_POS_W-1:0] w_col;
    logic [c_POS_W-1:0] w_row;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic [D_WIDTH-1:0] w_din;

    logic               r_wr_en;
    logic [D_WIDTH-1:0] r_din;
    logic [c_POS_W-1:0] r_row;
    logic [c_POS_W-1:0] r_col;
    logic               r_start;
    logic               r_done;
    logic               r_overflow;
    logic               r_drop;

    // Pixels are counted even when the FIFO is full so geometry stays aligned.
    assign w_accept = pixel_i_valid && (r_state != c_ST_WAIT);
    assign w_first  = w_accept && (r_state == c_ST_IDLE);
    assign w_last   = w_col_wrap && w_row_wrap;
    assign w_din    = D_WIDTH'(pixel_i) << PIX_SHIFT;

    mod_N_counter #(
        .N (IMG_DIM),
        .W (c_POS_W)
    ) u_col_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear_i),
        .i_en    (w_accept),
        .o_count (w_col),
        .o_wrap  (w_col_wrap)
    );

    mod_N_counter #(
        .N (IMG_DIM),
        .W (c_POS_W)
    ) u_row_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear_i),
        .i_en    (w_col_wrap),
        .o_count (w_row),
        .o_wrap  (w_row_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_nxt = w_last ? c_ST_WAIT : c_ST_RECV;
            c_ST_RECV: if (w_last)   w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (result_valid_i) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= 1'b0;
        end else if (clear_i) begin
            r_state    <= c_ST_IDLE;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= w_accept && !fifo_full;
            r_start <= w_first;
            r_done  <= w_last;
            if (w_accept) begin
                r_din <= w_din;
                r_row <= w_row;
                r_col <= w_col;
            end
            if (w_accept && fifo_full) begin
                r_overflow <= 1'b1;
            end
            // A pixel in the release cycle is still lost; the frame restarts after.
            if (pixel_i_valid && (r_state == c_ST_WAIT)) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign fifo_wr_en    = r_wr_en;
    assign fifo_din      = r_din;
    assign row_o         = r_row;
    assign col_o         = r_col;
    assign frame_start_o = r_start;
    assign frame_done_o  = r_done;
    assign busy_o        = (r_state == c_ST_WAIT);
    assign overflow_o    = r_overflow;
    assign drop_o        = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pixel_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_ingress
//  Description : Directed self-checking bench for pixel_ingress.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_ingress;

    logic        clk;
    logic        rst;
    logic        clear_i;
    logic [7:0]  pixel_i;
    logic        pixel_i_valid;
    logic        result_valid_i;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic [4:0]  row_o;
    logic [4:0]  col_o;
    logic        frame_start_o;
    logic        frame_done_o;
    logic        busy_o;
    logic        overflow_o;
    logic        drop_o;

    logic [7:0]  s8_pixel;
    logic        s8_valid;
    logic        s8_wr_en;
    logic [15:0] s8_din;
    logic [4:0]  s8_row;
    logic [4:0]  s8_col;
    logic        s8_start;
    logic        s8_done;
    logic        s8_busy;
    logic        s8_ovf;
    logic        s8_drop;

    int n_vec = 0;
    int n_err = 0;

    pixel_ingress #(
        .GS_BITS(8), .D_WIDTH(16), .IMG_DIM(30), .PIX_SHIFT(0)
    ) u_dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .pixel_i(pixel_i), .pixel_i_valid(pixel_i_valid),
        .result_valid_i(result_valid_i), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .row_o(row_o), .col_o(col_o),
        .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
        .busy_o(busy_o), .overflow_o(overflow_o), .drop_o(drop_o)
    );

    pixel_ingress #(
        .GS_BITS(8), .D_WIDTH(16), .IMG_DIM(30), .PIX_SHIFT(8)
    ) u_dut_sh8 (
        .clk(clk), .rst(rst), .clear_i(1'b0),
        .pixel_i(s8_pixel), .pixel_i_valid(s8_valid),
        .result_valid_i(1'b0), .fifo_full(1'b0),
        .fifo_wr_en(s8_wr_en), .fifo_din(s8_din),
        .row_o(s8_row), .col_o(s8_col),
        .frame_start_o(s8_start), .frame_done_o(s8_done),
        .busy_o(s8_busy), .overflow_o(s8_ovf), .drop_o(s8_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] p, input logic full);
        pixel_i       = p;
        pixel_i_valid = 1'b1;
        fifo_full     = full;
        tick();
        pixel_i_valid = 1'b0;
        fifo_full     = 1'b0;
    endtask

    int nwr, nst, ndn, perr;

    initial begin
        rst = 1'b1; clear_i = 1'b0; pixel_i = '0; pixel_i_valid = 1'b0;
        result_valid_i = 1'b0; fifo_full = 1'b0; s8_pixel = '0; s8_valid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_din",   32'(fifo_din), 0);
        chk("rst_rowcol", {row_o, col_o}, 0);
        chk("rst_flags", {frame_start_o, frame_done_o, busy_o, overflow_o, drop_o}, 0);
        rst = 1'b0;
        tick();

        // Shifted widening on the second instance
        s8_pixel = 8'hA5; s8_valid = 1'b1;
        tick();
        s8_valid = 1'b0;
        chk("sh8_din", 32'(s8_din), 32'hA500);
        chk("sh8_wr_en", 32'(s8_wr_en), 1);
        chk("sh8_pos_start", {s8_row, s8_col, s8_start}, {10'd0, 1'b1});
        tick();
        chk("sh8_wr_once", 32'(s8_wr_en), 0);

        // Full frame
        nwr = 0; nst = 0; ndn = 0; perr = 0;
        for (int i = 0; i < 900; i++) begin
            push(8'(i), 1'b0);
            if (fifo_wr_en) nwr++;
            if (frame_start_o) begin nst++; if (i != 0) perr++; end
            if (frame_done_o) begin ndn++; if (i != 899) perr++; end
            if (i < 899 && busy_o) perr++;
            if (row_o != 5'(i / 30) || col_o != 5'(i % 30) || fifo_din != 16'(i % 256)) perr++;
        end
        chk("f1_writes", nwr, 900);
        chk("f1_starts", nst, 1);
        chk("f1_dones", ndn, 1);
        chk("f1_seq_errs", perr, 0);
        chk("f1_last_pos", {row_o, col_o}, {5'd29, 5'd29});
        chk("f1_busy", 32'(busy_o), 1);

        // Pixels during WAIT, then a pixel in the release cycle
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            push(8'(8'hE0 + i), 1'b0);
            if (fifo_wr_en) nwr++;
        end
        pixel_i = 8'h77; pixel_i_valid = 1'b1; result_valid_i = 1'b1;
        tick();
        pixel_i_valid = 1'b0; result_valid_i = 1'b0;
        if (fifo_wr_en) nwr++;
        chk("wait_writes", nwr, 0);
        chk("wait_drop", 32'(drop_o), 1);
        chk("wait_release_busy", 32'(busy_o), 0);
        push(8'h3C, 1'b0);
        chk("restart_start", {frame_start_o, fifo_wr_en}, 2'b11);
        chk("restart_pos", {row_o, col_o}, 0);
        chk("restart_din", 32'(fifo_din), 32'h003C);

        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clear_flags", {drop_o, overflow_o, busy_o, fifo_wr_en}, 0);
        chk("clear_outs", {row_o, col_o, fifo_din}, 0);

        // Geometry and overflow
        for (int i = 0; i < 102; i++) begin
            push(8'(i), i == 100);
            if (i == 30) chk("p30_pos", {row_o, col_o}, {5'd1, 5'd0});
            if (i == 100) begin
                chk("p100_no_write", 32'(fifo_wr_en), 0);
                chk("p100_ovf", 32'(overflow_o), 1);
                chk("p100_pos", {row_o, col_o}, {5'd3, 5'd10});
            end
            if (i == 101) begin
                chk("p101_write", 32'(fifo_wr_en), 1);
                chk("p101_pos", {row_o, col_o}, {5'd3, 5'd11});
                chk("p101_ovf_sticky", 32'(overflow_o), 1);
            end
        end
        for (int i = 102; i < 450; i++) push(8'(i), 1'b0);
        chk("p449_pos", {row_o, col_o}, {5'd14, 5'd29});
        chk("p449_ovf", 32'(overflow_o), 1);

        // Asynchronous reset mid-frame, between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outs", {row_o, col_o, fifo_din}, 0);
        chk("arst_flags", {fifo_wr_en, overflow_o, drop_o, busy_o}, 0);
        #1;
        rst = 1'b0;
        tick();
        push(8'h5A, 1'b0);
        chk("arst_restart", {frame_start_o, fifo_wr_en, row_o, col_o}, {2'b11, 10'd0});

        // Two back-to-back frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nwr = 0; nst = 0; ndn = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 900; i++) begin
                push(8'(i * 7), 1'b0);
                if (fifo_wr_en) nwr++;
                if (frame_start_o) nst++;
                if (frame_done_o) ndn++;
            end
            result_valid_i = 1'b1;
            tick();
            result_valid_i = 1'b0;
        end
        chk("f2_writes", nwr, 1800);
        chk("f2_starts_dones", {16'(nst), 16'(ndn)}, {16'd2, 16'd2});
        chk("f2_sticky", {overflow_o, drop_o, busy_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
